jk_excite_ctrl: RTL and testbench
=================================

JK_EXCITE_CTRL -- requirements
Module: jk_excite_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, number of JK cells driven.
REQ-002 Parameter: MAX_RETRY, default 3, drive attempts after the first before the error is flagged (range 0-15).
REQ-003 Port: CLK  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port: RST  input  1  reset, synchronous, active-low.
REQ-005 Port: TGT_VALID  input  1  target word offered.
REQ-006 Port: TGT_READY  output  1  controller can accept a target.
REQ-007 Port: TGT_DATA  input  WIDTH  desired next state of the external JK bank.
REQ-008 Port: Q_FB  input  WIDTH  present Q of the external JK bank.
REQ-009 Port: J  output  WIDTH  J excitation to the bank.
REQ-010 Port: K  output  WIDTH  K excitation to the bank.
REQ-011 Port: DONE  output  1  one-cycle pulse: bank reached the target.
REQ-012 Port: ERR  output  1  sticky: target not reached within the allowed attempts.

Function
REQ-013 FSM states: IDLE, DRIVE, CHECK, DONE_ST, FAIL; encoding is free.
REQ-014 IDLE: TGT_READY=1, J=K=0; on TGT_VALID&TGT_READY, latch TGT_DATA into tgt_q, clear the attempt counter and ERR, then go to DRIVE.
REQ-015 TGT_READY is 1 only in IDLE and FAIL; a target offered in any other state is not accepted and has no effect.
REQ-016 DRIVE lasts exactly one cycle; per bit i, with q=Q_FB[i] and t=tgt_q[i], J and K follow the excitation table (REQ-017); the next state is CHECK.
REQ-017 Excitation table: q=0,t=0 -> J=0,K=0; q=0,t=1 -> J=1,K=0; q=1,t=0 -> J=0,K=1; q=1,t=1 -> J=0,K=0.
REQ-018 J and K are 0 in every state except DRIVE.
REQ-019 CHECK, with J=K=0: if Q_FB==tgt_q, go to DONE_ST; otherwise apply the retry rule (REQ-027/REQ-028).
REQ-020 DONE_ST lasts one cycle with DONE=1, then returns to IDLE.
REQ-021 Latency: accept edge at cycle N -> J/K driven in cycle N+1 -> Q_FB compared in cycle N+2 -> DONE high in cycle N+3.
REQ-022 A target equal to the current Q_FB still runs DRIVE (J=K=0 on all bits) and CHECK, and DONE pulses at N+3.
REQ-023 FAIL: ERR=1, J=K=0, TGT_READY=1; a new accept clears ERR and enters DRIVE.
REQ-024 ERR, once set, holds until the next accept or reset.
REQ-025 The attempt counter is 4 bits wide and saturates; it must not wrap.

Reset
REQ-026 While RST=0 at a clock edge: state=IDLE, tgt_q=0, attempt counter=0, J=0, K=0, DONE=0, ERR=0, TGT_READY=1 on the following cycle. Reset in any state, including mid-DRIVE, aborts the operation and produces no DONE pulse.

Configuration
REQ-027 Macro JKX_RETRY_EN defined: a CHECK mismatch with attempt counter < MAX_RETRY increments the counter and returns to DRIVE, recomputing J/K from the current Q_FB; a mismatch with counter == MAX_RETRY goes to FAIL.
REQ-028 Macro JKX_RETRY_EN undefined: any CHECK mismatch goes directly to FAIL; the attempt counter and MAX_RETRY are unused.

Verification
REQ-029 Reset then idle: RST=0 for 2 cycles, then 1 -> J=K=0, DONE=0, ERR=0, TGT_READY=1.
REQ-030 Ideal bank model, WIDTH=8, Q=0x00, target 0xA5 -> DRIVE shows J=0xA5, K=0x00; DONE at N+3; bank Q=0xA5.
REQ-031 From Q=0xA5, target 0x5A -> J=0x5A, K=0xA5; DONE at N+3; Q=0x5A; TGT_VALID held high during the operation is not accepted again until IDLE.
REQ-032 Bank bit 0 stuck at 0, target 0x01, JKX_RETRY_EN defined, MAX_RETRY=3 -> four DRIVE cycles each with J[0]=1, then FAIL, ERR=1, no DONE; the next accept clears ERR.
REQ-033 Same stuck bit with JKX_RETRY_EN undefined -> a single DRIVE, then FAIL and ERR=1 at cycle N+3.
REQ-034 RST=0 asserted during DRIVE -> J=K=0 and IDLE on the next cycle, no DONE, ERR=0.

Source files
------------

// File: rtl/jk_excite_ctrl.sv
// jk_excite_ctrl: drives J/K of an external JK bank toward a target word.
// Define JKX_RETRY_EN to re-drive up to MAX_RETRY times before flagging ERR.
module jk_excite_ctrl #(
  parameter int WIDTH     = 8,
  parameter int MAX_RETRY = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             TGT_VALID,
  output logic             TGT_READY,
  input  logic [WIDTH-1:0] TGT_DATA,
  input  logic [WIDTH-1:0] Q_FB,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic             DONE,
  output logic             ERR
);

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    CHECK,
    DONE_ST,
    FAIL
  } state_t;

  if (MAX_RETRY < 0 || MAX_RETRY > 15) begin : g_bad_retry
    $error("MAX_RETRY must be within 0..15");
  end

`ifdef JKX_RETRY_EN
  localparam logic [3:0] RetryLim = MAX_RETRY[3:0];
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             err_q, err_d;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    J         = '0;
    K         = '0;
    DONE      = 1'b0;
    TGT_READY = 1'b0;
    unique case (state_q)
      IDLE, FAIL: begin
        TGT_READY = 1'b1;
        if (TGT_VALID) begin
          tgt_d   = TGT_DATA;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        // set only 0->1 bits, reset only 1->0 bits, hold the rest
        J       = ~Q_FB & tgt_q;
        K       = Q_FB & ~tgt_q;
        state_d = CHECK;
      end
      CHECK: begin
        if (Q_FB == tgt_q) begin
          state_d = DONE_ST;
        end else begin
`ifdef JKX_RETRY_EN
          if (cnt_q < RetryLim) begin
            cnt_d   = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
            state_d = DRIVE;
          end else begin
            err_d   = 1'b1;
            state_d = FAIL;
          end
`else
          err_d   = 1'b1;
          state_d = FAIL;
`endif
        end
      end
      DONE_ST: begin
        DONE    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ERR = err_q;

endmodule

// File: tb/tb_jk_excite_ctrl.sv
// tb_jk_excite_ctrl: directed + random targets against an ideal JK bank
// with an optional stuck-at-0 mask; expected excitation from the JK table.
module tb_jk_excite_ctrl;

  logic       CLK;
  logic       RST;
  logic       TGT_VALID;
  logic       TGT_READY;
  logic [7:0] TGT_DATA;
  logic [7:0] Q_FB;
  logic [7:0] J;
  logic [7:0] K;
  logic       DONE;
  logic       ERR;

  int checks = 0;
  int errors = 0;

  logic [7:0] qb = 8'h00;
  logic [7:0] stuck = 8'h00;

  jk_excite_ctrl #(
    .WIDTH    (8),
    .MAX_RETRY(3)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .TGT_VALID(TGT_VALID),
    .TGT_READY(TGT_READY),
    .TGT_DATA (TGT_DATA),
    .Q_FB     (Q_FB),
    .J        (J),
    .K        (K),
    .DONE     (DONE),
    .ERR      (ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // External JK bank: per-bit JK flip-flop behaviour, stuck bits read 0.
  always @(posedge CLK) begin
    for (int i = 0; i < 8; i++) begin
      case ({J[i], K[i]})
        2'b00:   qb[i] <= qb[i] & ~stuck[i];
        2'b10:   qb[i] <= ~stuck[i];
        2'b01:   qb[i] <= 1'b0;
        default: qb[i] <= ~qb[i] & ~stuck[i];
      endcase
    end
  end
  assign Q_FB = qb;

  function automatic logic [15:0] excite(input logic [7:0] q,
                                         input logic [7:0] t);
    logic [7:0] jj;
    logic [7:0] kk;
    for (int i = 0; i < 8; i++) begin
      case ({q[i], t[i]})
        2'b00:   begin jj[i] = 1'b0; kk[i] = 1'b0; end
        2'b01:   begin jj[i] = 1'b1; kk[i] = 1'b0; end
        2'b10:   begin jj[i] = 1'b0; kk[i] = 1'b1; end
        default: begin jj[i] = 1'b0; kk[i] = 1'b0; end
      endcase
    end
    return {jj, kk};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One full operation from IDLE; ends back in IDLE.
  task automatic run_op(input logic [7:0] t, input logic hold);
    logic [15:0] e;
    TGT_VALID = 1'b1;
    TGT_DATA  = t;
    chk("idle_ready", {7'd0, TGT_READY}, 8'd1);
    step();
    e = excite(qb, t);
    chk("drv_j", J, e[15:8]);
    chk("drv_k", K, e[7:0]);
    chk("drv_done", {7'd0, DONE}, 8'd0);
    chk("drv_ready", {7'd0, TGT_READY}, 8'd0);
    chk("drv_err", {7'd0, ERR}, 8'd0);
    TGT_VALID = hold;
    TGT_DATA  = ~t;
    step();
    chk("chk_jk", J | K, 8'h00);
    chk("chk_done", {7'd0, DONE}, 8'd0);
    chk("chk_ready", {7'd0, TGT_READY}, 8'd0);
    chk("bank_q", qb, t);
    step();
    chk("done_pulse", {7'd0, DONE}, 8'd1);
    chk("done_jk", J | K, 8'h00);
    TGT_VALID = 1'b0;
    step();
    chk("post_done", {7'd0, DONE}, 8'd0);
    chk("post_ready", {7'd0, TGT_READY}, 8'd1);
  endtask

  initial begin
    logic [15:0] e;
    logic [7:0]  t;
    RST       = 1'b0;
    TGT_VALID = 1'b0;
    TGT_DATA  = 8'h00;
    step();
    step();
    RST = 1'b1;
    chk("rst_j", J, 8'h00);
    chk("rst_k", K, 8'h00);
    chk("rst_done", {7'd0, DONE}, 8'd0);
    chk("rst_err", {7'd0, ERR}, 8'd0);
    chk("rst_ready", {7'd0, TGT_READY}, 8'd1);
    step();
    chk("idle_jk", J | K, 8'h00);

    run_op(8'hA5, 1'b0);
    run_op(8'h5A, 1'b1);
    run_op(8'h5A, 1'b0);
    for (int n = 0; n < 16; n++) begin
      run_op(8'($urandom), 1'($urandom_range(0, 1)));
    end

    // Bank bit 0 stuck at 0, target requires it set.
    stuck = 8'h01;
    step();
    TGT_VALID = 1'b1;
    TGT_DATA  = 8'h01;
    step();
    TGT_VALID = 1'b0;
`ifdef JKX_RETRY_EN
    for (int a = 0; a <= 3; a++) begin
      e = excite(qb, 8'h01);
      chk("rty_j", J, e[15:8]);
      chk("rty_j0", {7'd0, J[0]}, 8'd1);
      chk("rty_k", K, e[7:0]);
      chk("rty_done", {7'd0, DONE}, 8'd0);
      step();
      chk("rty_chk_jk", J | K, 8'h00);
      chk("rty_chk_done", {7'd0, DONE}, 8'd0);
      chk("rty_chk_err", {7'd0, ERR}, 8'd0);
      step();
    end
`else
    e = excite(qb, 8'h01);
    chk("one_j", J, e[15:8]);
    chk("one_k", K, e[7:0]);
    step();
    chk("one_chk_done", {7'd0, DONE}, 8'd0);
    chk("one_chk_err", {7'd0, ERR}, 8'd0);
    step();
`endif
    chk("fail_err", {7'd0, ERR}, 8'd1);
    chk("fail_ready", {7'd0, TGT_READY}, 8'd1);
    chk("fail_done", {7'd0, DONE}, 8'd0);
    chk("fail_jk", J | K, 8'h00);
    step();
    step();
    chk("fail_sticky", {7'd0, ERR}, 8'd1);
    chk("fail_nodone", {7'd0, DONE}, 8'd0);
    stuck = 8'h00;
    run_op(8'h3C, 1'b0);
    chk("err_cleared", {7'd0, ERR}, 8'd0);

    // Reset during DRIVE aborts without DONE.
    t = 8'($urandom) ^ qb;
    if (t == qb) t = ~qb;
    TGT_VALID = 1'b1;
    TGT_DATA  = t;
    step();
    TGT_VALID = 1'b0;
    e = excite(qb, t);
    chk("abort_drv_j", J, e[15:8]);
    RST = 1'b0;
    step();
    RST = 1'b1;
    chk("abort_jk", J | K, 8'h00);
    chk("abort_ready", {7'd0, TGT_READY}, 8'd1);
    chk("abort_done", {7'd0, DONE}, 8'd0);
    chk("abort_err", {7'd0, ERR}, 8'd0);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("abort_nodone", {7'd0, DONE}, 8'd0);
      chk("abort_idle_jk", J | K, 8'h00);
    end
    run_op(8'h81, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
